uart_mmio: RTL
==============

# uart_mmio

Memory-mapped 8N1 UART peripheral on the processor's data bus, in the 0x4000_0000+ peripheral region. Serializes bytes written by the core onto `uart_tx` and deserializes bytes from `uart_rx` into a readable register. Provides sticky status flags and a level interrupt to the core's interrupt input. Read data is zero whenever not selected, so the core can OR it with the data-memory read data.

## Interface
- `BAUD_DIV`, default 5208: clk cycles per bit; minimum 4.
- `BASE`, default 32'h4000_0018: word address of TXD; RXD is `BASE+4`, CON is `BASE+8`.

Ports:
- `clk` in 1: clock; all state changes on rising edge.
- `reset` in 1: reset, asynchronous, active-low.
- `rd` in 1: read strobe for the current cycle.
- `wr` in 1: write strobe, committed at the rising edge.
- `addr` in 32: byte address; bits [1:0] ignored.
- `wdata` in 32: write data.
- `rdata` out 32: combinational read data; 0 when `rd`=0 or `addr` is not TXD/RXD/CON.
- `uart_rx` in 1: serial input, asynchronous to `clk`, idle high.
- `uart_tx` out 1: serial output, idle high.
- `irq` out 1: interrupt request, level.

## Operation
- Registers:
  - TXD (W): `wdata[7:0]` is the byte to send. Reads return 0.
  - RXD (R): `{24'b0, rx_byte}`.
  - CON bits:
    - [0] tx_ie (RW)
    - [1] rx_ie (RW)
    - [2] tx_done: sticky; cleared by CON read.
    - [3] rx_valid: cleared by RXD read.
    - [4] tx_busy (RO)
    - [5] rx_overrun: sticky; cleared by CON read.
    - [6] frame_err: sticky; cleared by CON read.
    - [31:7] read as 0.
  - Writes to CON change only bits [1:0].
- Read side effects take place at the rising edge where `rd`=1 and the address matches.
- `irq = (tx_ie & tx_done) | (rx_ie & rx_valid)`. Driven from registered state only.
- TX FSM, states IDLE → START → DATA → STOP → IDLE:
  - A TXD write in IDLE latches the byte and sets tx_busy.
  - A TXD write while busy is dropped; no flag changes.
  - Each state holds for BAUD_DIV cycles, counted by a bit counter. DATA sends 8 bits LSB first.
  - At the end of STOP: tx_busy clears and tx_done sets.
- RX path:
  - `uart_rx` passes through a 2-flop synchronizer; both flops reset to 1.
- RX FSM, states IDLE → START → DATA → STOP → IDLE:
  - IDLE: a synchronized 0 moves the FSM to START.
  - START: wait BAUD_DIV/2 cycles (floor), then sample. If the sample is high, treat it as a glitch and return to IDLE with no flag change.
  - DATA: sample every BAUD_DIV cycles, 8 bits LSB first, into a shift register.
  - STOP: sample after BAUD_DIV cycles.
    - Stop bit = 1: copy the byte to `rx_byte` and set rx_valid. If rx_valid was already 1, also set rx_overrun; the new byte overwrites the old one.
    - Stop bit = 0: discard the byte, set frame_err, and leave `rx_byte` unchanged.
  - After STOP, return to IDLE and wait for line high before accepting a new start. A break condition therefore yields exactly one frame_err.
- Simultaneous events:
  - A flag set and a clear in the same cycle: set wins. This covers an RXD read with a byte completing, and a CON read with tx_done or overrun setting.
  - A CON write together with a CON read: the write applies and the read clears the sticky bits.
  - `wr` and `rd` both asserted to different registers: both take effect.

## Timing
- Reset values:
  - `uart_tx`=1, `irq`=0, `rdata`=0.
  - All CON bits 0, `rx_byte`=0.
  - Both FSMs in IDLE, all counters 0.
- Asynchronous reset mid-frame: `uart_tx` returns to 1 immediately and any partial RX byte is lost.
- TX latency:
  - A TXD write at edge N drives the start bit (`uart_tx`=0) from edge N+1.
  - Bit k occupies cycles N+1+k·BAUD_DIV through N+(k+1)·BAUD_DIV, where k=0 is start, 1–8 are data, and 9 is stop.
  - tx_done and tx_busy=0 take effect at edge N+1+10·BAUD_DIV.
- TX back-to-back: a TXD write issued the cycle tx_busy reads 0 starts the next start bit with no extra idle bit.
- RX latency: rx_valid sets at edge E+2+floor(BAUD_DIV/2)+9·BAUD_DIV (±1), where E is the first edge at which the pin is sampled low.
- `rdata` is combinational from `addr` and `rd`. It is valid in the same cycle and reflects register state before that edge's side effects.

## Test plan
- **Reset:** hold `reset`=0 mid-transmission → `uart_tx`=1, `irq`=0, and a CON read returns 0. After release, no spurious rx_valid while `uart_rx`=1.
- **TX byte** (BAUD_DIV=8): write 0x0000_00A5 to 0x4000_0018 →
  - `uart_tx` pattern 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles.
  - CON reads 0x10 during the frame and 0x04 afterwards; a second CON read returns 0x00.
  - A second write issued mid-frame is ignored: only one frame appears.
- **RX byte with interrupt:** write CON=0x2, then drive 8N1 0x3C on `uart_rx` →
  - `irq`=1 and CON[3]=1.
  - An RXD read returns 0x3C and drops `irq` the next cycle.
- **RX overrun and framing:**
  - Send 0x11 then 0x22 without reading → RXD=0x22, CON[5]=1.
  - Send a frame with stop bit 0 → CON[6]=1 and RXD unchanged.
  - A CON read clears bits 5 and 6.
- **Glitch:** pulse `uart_rx` low for 2 cycles (BAUD_DIV=8) → no flags set and the RX FSM returns to IDLE.
- **Collision:** complete an RX byte on the same edge as an RXD read → rx_valid stays 1 and RXD holds the new byte.

Source files
------------

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers on the data bus, sticky status
// flags and a level interrupt built only from registered state.
module uart_mmio #(
    parameter int unsigned BAUD_DIV = 5208,
    parameter logic [31:0] BASE     = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST      = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [29:0]   TXD_WORD  = BASE[31:2];
    localparam logic [29:0]   RXD_WORD  = TXD_WORD + 30'd1;
    localparam logic [29:0]   CON_WORD  = TXD_WORD + 30'd2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic sel_txd, sel_rxd, sel_con;
    logic wr_txd, wr_con, rd_rxd, rd_con;

    assign sel_txd = (addr[31:2] == TXD_WORD);
    assign sel_rxd = (addr[31:2] == RXD_WORD);
    assign sel_con = (addr[31:2] == CON_WORD);
    assign wr_txd  = wr & sel_txd;
    assign wr_con  = wr & sel_con;
    assign rd_rxd  = rd & sel_rxd;
    assign rd_con  = rd & sel_con;

    logic unused_bits;
    assign unused_bits = ^{wdata[31:8], addr[1:0]};

    logic       tx_ie, rx_ie, tx_done, rx_valid, tx_busy, rx_overrun, frame_err;
    logic [7:0] rx_byte;

    // ---------------- TX ----------------
    uart_state_t   tx_state, tx_state_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_tick, tx_accept, tx_end;

    assign tx_tick   = (tx_cnt == LAST);
    assign tx_accept = wr_txd & ~tx_busy;
    assign tx_end    = (tx_state == S_STOP) & tx_tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_next;
            if (tx_state == S_IDLE || tx_tick) tx_cnt <= '0;
            else                               tx_cnt <= tx_cnt + 1'b1;
            if (tx_accept) begin
                tx_shift <= wdata[7:0];
            end else if (tx_state == S_DATA && tx_tick) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
        end
    end

    // The byte is latched at the write edge; the frame starts one edge later.
    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            S_IDLE:  if (tx_busy) tx_state_next = S_START;
            S_START: if (tx_tick) tx_state_next = S_DATA;
            S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_state_next = S_STOP;
            S_STOP:  if (tx_tick) tx_state_next = S_IDLE;
            default: tx_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        uart_tx = 1'b1;
        case (tx_state)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = tx_shift[0];
            default: uart_tx = 1'b1;
        endcase
    end

    // ---------------- RX ----------------
    uart_state_t   rx_state, rx_state_next;
    logic          rx_meta, rx_sync, rx_armed;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_tick, rx_ok, rx_bad;

    assign rx_tick = (rx_state == S_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_armed <= 1'b0;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_state <= rx_state_next;
            if (rx_state == S_IDLE || rx_tick) rx_cnt <= '0;
            else                               rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == S_DATA && rx_tick) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
            // A held-low line (break) must go high before another start is accepted.
            if (rx_state == S_STOP)                 rx_armed <= 1'b0;
            else if (rx_state == S_IDLE && rx_sync) rx_armed <= 1'b1;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            S_IDLE:  if (rx_armed && !rx_sync) rx_state_next = S_START;
            S_START: if (rx_tick) rx_state_next = rx_sync ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_next = S_STOP;
            S_STOP:  if (rx_tick) rx_state_next = S_IDLE;
            default: rx_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ok  = 1'b0;
        rx_bad = 1'b0;
        if (rx_state == S_STOP && rx_tick) begin
            rx_ok  = rx_sync;
            rx_bad = ~rx_sync;
        end
    end

    // ---------------- Flags and registers ----------------
    // Setting events take priority over read-side clears on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ie      <= 1'b0;
            rx_ie      <= 1'b0;
            tx_done    <= 1'b0;
            rx_valid   <= 1'b0;
            tx_busy    <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            rx_byte    <= '0;
        end else begin
            if (wr_con) {rx_ie, tx_ie} <= wdata[1:0];
            if (tx_accept)   tx_busy <= 1'b1;
            else if (tx_end) tx_busy <= 1'b0;
            if (tx_end)      tx_done <= 1'b1;
            else if (rd_con) tx_done <= 1'b0;
            if (rx_ok)       rx_valid <= 1'b1;
            else if (rd_rxd) rx_valid <= 1'b0;
            if (rx_ok && rx_valid) rx_overrun <= 1'b1;
            else if (rd_con)       rx_overrun <= 1'b0;
            if (rx_bad)      frame_err <= 1'b1;
            else if (rd_con) frame_err <= 1'b0;
            if (rx_ok) rx_byte <= rx_shift;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_rxd)      rdata = {24'b0, rx_byte};
            else if (sel_con) rdata = {25'b0, frame_err, rx_overrun, tx_busy,
                                       rx_valid, tx_done, rx_ie, tx_ie};
        end
    end

    assign irq = (tx_ie & tx_done) | (rx_ie & rx_valid);

endmodule
